io_timer: RTL
=============

# io_timer

8-bit timer/counter peripheral on the I/O bus, downstream of the control unit. It decodes `bus_addr` and answers the `io_cs`/`io_we`/`io_oe` strobes that the control unit issues for IN/OUT/SBI/CBI. It provides a prescaled free-running counter, a compare register, overflow and compare-match flags, and a level interrupt request.

## Interface
- `DATA_WIDTH`, 8, register and data-bus width; the design is only defined for 8.
- `ADDR_WIDTH`, 16, I/O address width.
- `BASE_ADDR`, 16'h0020, address of the first register. The block occupies BASE..BASE+3, below the memory window at 8'h40.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; low forces all state to its reset value immediately.
- `bus_addr`  in  ADDR_WIDTH  I/O address from the control unit.
- `bus_data`  inout  DATA_WIDTH  shared data bus; driven only during a decoded read, high-Z otherwise.
- `io_cs`  in  1  I/O chip select.
- `io_we`  in  1  write strobe, qualified by `io_cs`.
- `io_oe`  in  1  read strobe, qualified by `io_cs`.
- `irq`  out  1  interrupt request, level-high.

## Operation
- Register map, offset from BASE:
  - +0 TCCR: [2:0] CS, [3] CTC, [4] TOIE, [5] OCIE, [7:6] read 0.
  - +1 TCNT: counter.
  - +2 OCR: compare value.
  - +3 TIFR: [0] TOV, [1] OCF, [7:2] read 0.
- Hit: `io_cs` high and `bus_addr` in BASE..BASE+3. A miss means no drive and no state change.
- Write: hit with `io_we` high.
  - TCCR, TCNT and OCR load `bus_data` at the edge.
  - TIFR is write-1-to-clear per bit; 0 bits are unaffected.
- Read: hit with `io_oe` and not `io_we`. `bus_data` is driven combinationally with the addressed register. `io_we` and `io_oe` together is treated as a write and the bus is not driven.
- Prescaler: a 10-bit counter `pre` generates a one-cycle `tick`.
  - Division by CS: 0 stopped (no ticks, `pre` held at 0); 1 divides by 1 (tick every cycle); 2 by 8; 3 by 64; 4 by 256; 5 by 1024; 6 and 7 stopped.
  - `tick` asserts when `pre` equals divisor-1. `pre` then wraps to 0; otherwise `pre` increments.
  - Any write to TCCR clears `pre` to 0 in that cycle.
- Counting on `tick`:
  - If TCNT==OCR: set OCF. If CTC=1, TCNT loads 0; else TCNT increments.
  - Else TCNT increments mod 256. A 8'hFF to 8'h00 wrap sets TOV. TOV is never set by a CTC clear.
  - TCNT==OCR==8'hFF with CTC=0 sets both OCF and TOV on the same tick.
- `irq` = (TOV & TOIE) | (OCF & OCIE), combinational from registers.

## Timing
- Reset values: TCCR=0, TCNT=0, OCR=0, TIFR=0, `pre`=0. `irq`=0 and `bus_data` high-Z.
- Reset release: the first edge with `reset` high performs normal operation. Reset asserted mid-count clears everything asynchronously and drops `irq` within the same cycle.
- Write latency: the register holds the new value in the cycle after the write edge. A read in that cycle returns the new value.
- Read latency: zero. The data is valid while `cs&oe` is held and is sampled by the control unit at its next edge.
- Collisions:
  - A CPU write to TCNT on a tick edge wins. TCNT takes the written value, and no increment, OCF or TOV results from that tick.
  - A TIFR clear on the same edge as a flag-set event: set wins and the flag stays 1.
  - A write to OCR on a tick edge: the compare on that tick uses the old OCR.
  - A TCCR write on a tick edge: the tick is consumed with the old CTC, and `pre` restarts at 0.
- With CS=1 and CTC=0 the counter period is 256 cycles. With CTC=1 the period is (OCR+1) ticks.

## Test plan
- Reset/readback: hold `reset` low, then release. Read all four offsets, expecting 0. Read with `io_oe` low and with an out-of-range address (BASE+4, 8'h40); `bus_data` must be Z.
- Overflow: write TCCR=8'h11 (CS=1, TOIE) and TCNT=8'hFD. After 3 cycles TCNT=0, TOV=1 and `irq`=1. Write TIFR=8'h01; TOV=0 and `irq`=0 the next cycle.
- Prescaler /8: write TCCR=8'h02 and TCNT=0. TCNT=1 exactly 8 cycles after the write edge and 2 after 16. Rewriting TCCR at cycle 5 delays the next increment to 8 cycles after the rewrite.
- CTC: write OCR=8'h04 and TCCR=8'h29 (CS=1, CTC, OCIE). TCNT sequence is 0,1,2,3,4,0,1. OCF=1 and `irq`=1 after the 4 to 0 transition; TOV stays 0.
- Collisions: with CS=1, write TCNT=8'h10 on a tick edge; the next cycle reads 8'h10. With TCNT=8'hFF, write TIFR=8'h01 on the wrapping edge; TOV=1.
- Async reset mid-run: with CS=1 counting and `irq` high, pulse `reset` low between edges. All registers read 0 and `irq`=0 before the next edge.

Source files
------------

// File: rtl/io_timer_if.sv
// I/O strobe and address bundle between the control unit and peripherals.
// The shared data bus stays a separate tristate port on each peripheral.
interface io_timer_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  io_cs;
  logic                  io_we;
  logic                  io_oe;

  modport master (
    output bus_addr, io_cs, io_we, io_oe
  );

  modport slave (
    input bus_addr, io_cs, io_we, io_oe
  );
endinterface

// File: rtl/io_timer.sv
// 8-bit prescaled timer/counter with compare, overflow/match flags and
// a level interrupt, mapped at BASE..BASE+3 on the I/O bus.
module io_timer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0020
) (
  input  logic                  clk,
  input  logic                  reset,
  io_timer_if.slave             bus,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  output logic                  irq
);

  logic [5:0] tccr_q, tccr_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [7:0] ocr_q, ocr_d;
  logic       tov_q, tov_d;
  logic       ocf_q, ocf_d;
  logic [9:0] pre_q, pre_d;

  logic [ADDR_WIDTH-1:0] off;
  logic       hit, wr, rd;
  logic       wr_tccr, wr_tcnt, wr_ocr, wr_tifr;
  logic [7:0] wdata, rdata;
  logic [2:0] cs;
  logic       ctc, toie, ocie;
  logic [9:0] lim;
  logic       run, tick, match;
  logic       tov_set, ocf_set;

  assign off   = bus.bus_addr - BASE_ADDR;
  assign hit   = bus.io_cs && (off < ADDR_WIDTH'(4));
  assign wr    = hit && bus.io_we;
  assign rd    = hit && bus.io_oe && !bus.io_we;
  assign wdata = bus_data;

  assign wr_tccr = wr && (off[1:0] == 2'd0);
  assign wr_tcnt = wr && (off[1:0] == 2'd1);
  assign wr_ocr  = wr && (off[1:0] == 2'd2);
  assign wr_tifr = wr && (off[1:0] == 2'd3);

  assign cs   = tccr_q[2:0];
  assign ctc  = tccr_q[3];
  assign toie = tccr_q[4];
  assign ocie = tccr_q[5];

  // Terminal prescaler count for each clock select; 0, 6, 7 stop.
  always_comb begin
    lim = '0;
    run = 1'b1;
    unique case (cs)
      3'd1:    lim = 10'd0;
      3'd2:    lim = 10'd7;
      3'd3:    lim = 10'd63;
      3'd4:    lim = 10'd255;
      3'd5:    lim = 10'd1023;
      default: run = 1'b0;
    endcase
  end

  assign tick  = run && (pre_q == lim);
  assign match = (tcnt_q == ocr_q);

  always_comb begin
    pre_d = pre_q + 10'd1;
    if (wr_tccr || !run || tick) begin
      pre_d = '0;
    end
  end

  // A CPU write to TCNT wins over the tick and suppresses its flags.
  always_comb begin
    tcnt_d  = tcnt_q;
    tov_set = 1'b0;
    ocf_set = 1'b0;
    if (wr_tcnt) begin
      tcnt_d = wdata;
    end else if (tick) begin
      ocf_set = match;
      if (match && ctc) begin
        tcnt_d = '0;
      end else begin
        tcnt_d  = tcnt_q + 8'd1;
        tov_set = (tcnt_q == 8'hFF);
      end
    end
  end

  always_comb begin
    tccr_d = wr_tccr ? wdata[5:0] : tccr_q;
    ocr_d  = wr_ocr ? wdata : ocr_q;
    tov_d  = (tov_q && !(wr_tifr && wdata[0])) || tov_set;
    ocf_d  = (ocf_q && !(wr_tifr && wdata[1])) || ocf_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tccr_q <= '0;
      tcnt_q <= '0;
      ocr_q  <= '0;
      tov_q  <= 1'b0;
      ocf_q  <= 1'b0;
      pre_q  <= '0;
    end else begin
      tccr_q <= tccr_d;
      tcnt_q <= tcnt_d;
      ocr_q  <= ocr_d;
      tov_q  <= tov_d;
      ocf_q  <= ocf_d;
      pre_q  <= pre_d;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (off[1:0])
      2'd0: rdata = {2'b00, tccr_q};
      2'd1: rdata = tcnt_q;
      2'd2: rdata = ocr_q;
      2'd3: rdata = {6'd0, ocf_q, tov_q};
      default: rdata = '0;
    endcase
  end

  assign bus_data = rd ? rdata : 'z;
  assign irq = (tov_q && toie) || (ocf_q && ocie);

endmodule
